// File: rtl/frac_div_pkg.sv
// Shared types, reset defaults and config checks for the programmable fractional clock divider.
package frac_div_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int unsigned W_DEF     = 4;
    localparam int unsigned M_DEF_RST = 3;
    localparam int unsigned N_DEF_RST = 7;

    // A ratio is usable only when 0 < m <= n.
    function automatic logic cfg_legal(input int unsigned m, input int unsigned n);
        return (m != 0) && (n != 0) && (m <= n);
    endfunction

    function automatic logic defaults_ok(input int unsigned w, input int unsigned m,
                                         input int unsigned n);
        return (m != 0) && (m <= n) && (n < (32'd1 << w));
    endfunction

endpackage

// File: rtl/clk_gate_cell.sv
// Latch-based clock gate: enable captured while clk is low, so clk_out never glitches while clk is high.
module clk_gate_cell (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    output logic clk_out
);

    logic en_lat;

    always_latch begin
        if (!reset_n) begin
            en_lat <= 1'b0;
        end else if (!clk) begin
            en_lat <= en;
        end
    end

    assign clk_out = clk & en_lat;

endmodule

// File: rtl/frac_clk_div_prog.sv
// Runtime-programmable M/N fractional clock divider with boundary-aligned config update and gated clock.
module frac_clk_div_prog
    import frac_div_pkg::*;
#(
    parameter int unsigned W     = W_DEF,
    parameter int unsigned M_DEF = M_DEF_RST,
    parameter int unsigned N_DEF = N_DEF_RST
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         run_i,
    input  logic         cfg_valid_i,
    input  logic [W-1:0] cfg_m_i,
    input  logic [W-1:0] cfg_n_i,
    output logic         cfg_ready_o,
    output logic         cfg_err_o,
    output logic         clk_en_o,
    output logic         period_o,
    output logic         clk_out
);

    if (!defaults_ok(W, M_DEF, N_DEF)) begin : g_bad_defaults
        $error("frac_clk_div_prog: requires 0 < M_DEF <= N_DEF < 2**W");
    end

    state_t       state, state_nxt;
    logic [W-1:0] acc, acc_nxt;
    logic [W-1:0] phase, phase_nxt;
    logic [W-1:0] m_r, m_nxt, n_r, n_nxt;
    logic [W-1:0] m_sh, m_sh_nxt, n_sh, n_sh_nxt;
    logic         pending, pending_nxt;
    logic         en_nxt, per_nxt, err_nxt;
    logic [W:0]   sum;
    logic         accept, legal, boundary;

    assign accept   = cfg_valid_i & cfg_ready_o;
    assign legal    = cfg_legal(32'(cfg_m_i), 32'(cfg_n_i));
    assign sum      = {1'b0, acc} + {1'b0, m_r};
    assign boundary = (phase == (n_r - W'(1)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            acc         <= '0;
            phase       <= '0;
            m_r         <= W'(M_DEF);
            n_r         <= W'(N_DEF);
            m_sh        <= '0;
            n_sh        <= '0;
            pending     <= 1'b0;
            cfg_ready_o <= 1'b1;
            cfg_err_o   <= 1'b0;
            clk_en_o    <= 1'b0;
            period_o    <= 1'b0;
        end else begin
            state       <= state_nxt;
            acc         <= acc_nxt;
            phase       <= phase_nxt;
            m_r         <= m_nxt;
            n_r         <= n_nxt;
            m_sh        <= m_sh_nxt;
            n_sh        <= n_sh_nxt;
            pending     <= pending_nxt;
            cfg_ready_o <= ~pending_nxt;
            cfg_err_o   <= err_nxt;
            clk_en_o    <= en_nxt;
            period_o    <= per_nxt;
        end
    end

    // Next-state: run/stop control, accumulator step, and where a new ratio lands.
    always_comb begin
        state_nxt   = state;
        acc_nxt     = acc;
        phase_nxt   = phase;
        m_nxt       = m_r;
        n_nxt       = n_r;
        m_sh_nxt    = m_sh;
        n_sh_nxt    = n_sh;
        pending_nxt = pending;
        en_nxt      = 1'b0;
        per_nxt     = 1'b0;
        err_nxt     = accept & ~legal;

        case (state)
            IDLE: begin
                acc_nxt   = '0;
                phase_nxt = '0;
                if (accept && legal) begin
                    m_nxt = cfg_m_i;
                    n_nxt = cfg_n_i;
                end
                if (run_i) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!run_i) begin
                    state_nxt = IDLE;
                    acc_nxt   = '0;
                    phase_nxt = '0;
                    if (pending) begin
                        m_nxt       = m_sh;
                        n_nxt       = n_sh;
                        pending_nxt = 1'b0;
                    end else if (accept && legal) begin
                        m_nxt = cfg_m_i;
                        n_nxt = cfg_n_i;
                    end
                end else begin
                    if (sum >= {1'b0, n_r}) begin
                        acc_nxt = W'(sum - {1'b0, n_r});
                        en_nxt  = 1'b1;
                    end else begin
                        acc_nxt = W'(sum);
                    end
                    per_nxt   = boundary;
                    phase_nxt = boundary ? '0 : phase + W'(1);
                    // The period in flight finishes on the old ratio; swap only at its last cycle.
                    if (boundary && pending) begin
                        m_nxt       = m_sh;
                        n_nxt       = n_sh;
                        acc_nxt     = '0;
                        pending_nxt = 1'b0;
                    end
                    if (accept && legal) begin
                        m_sh_nxt    = cfg_m_i;
                        n_sh_nxt    = cfg_n_i;
                        pending_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    clk_gate_cell u_gate (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (clk_en_o),
        .clk_out (clk_out)
    );

endmodule

// File: tb/tb_frac_clk_div_prog.sv
// Directed bench for frac_clk_div_prog: closed-form M/N pass model feeding a scoreboard queue.
module tb_frac_clk_div_prog;

    localparam int unsigned W    = 4;
    localparam int unsigned HALF = 5;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         run_i = 1'b0;
    logic         cfg_valid_i = 1'b0;
    logic [W-1:0] cfg_m_i = '0;
    logic [W-1:0] cfg_n_i = '0;
    logic         cfg_ready_o, cfg_err_o, clk_en_o, period_o, clk_out;

    frac_clk_div_prog #(.W(W), .M_DEF(3), .N_DEF(7)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .run_i       (run_i),
        .cfg_valid_i (cfg_valid_i),
        .cfg_m_i     (cfg_m_i),
        .cfg_n_i     (cfg_n_i),
        .cfg_ready_o (cfg_ready_o),
        .cfg_err_o   (cfg_err_o),
        .clk_en_o    (clk_en_o),
        .period_o    (period_o),
        .clk_out     (clk_out)
    );

    always #(HALF) clk = ~clk;

    typedef struct {
        logic en;
        logic per;
        logic rdy;
        logic err;
        logic gclk;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference state: ratio, position inside the current period, pending shadow.
    int   b_m = 3, b_n = 7, b_k = 0, b_sm = 0, b_sn = 0;
    logic b_run = 1'b0, b_pend = 1'b0, b_rdy = 1'b1, prev_en = 1'b0;

    int   pulses = 0;
    int   c0;
    time  t_rise = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Clock k (1-based) of an M/N period passes when floor(k*M/N) steps up.
    function automatic logic passes(input int k, input int m, input int n);
        return ((k * m) / n) > (((k - 1) * m) / n);
    endfunction

    always @(posedge clk_out) begin
        pulses++;
        t_rise = $time;
    end

    always @(negedge clk_out) begin
        if (reset_n) chk("clk_out_width", 32'(($time - t_rise) >= HALF), 32'd1);
    end

    task automatic cyc(input logic run, input logic v, input int cm, input int cn);
        exp_t e, got;
        logic acc_ok, lg;
        int   k1;
        run_i       = run;
        cfg_valid_i = v;
        cfg_m_i     = W'(cm);
        cfg_n_i     = W'(cn);
        acc_ok      = v && b_rdy;
        lg          = (cm != 0) && (cn != 0) && (cm <= cn);
        e.err       = acc_ok && !lg;
        e.en        = 1'b0;
        e.per       = 1'b0;
        e.gclk      = prev_en;
        if (b_run && run) begin
            k1    = b_k + 1;
            e.en  = passes(k1, b_m, b_n);
            e.per = (k1 == b_n);
            b_k   = e.per ? 0 : k1;
            if (e.per && b_pend) begin
                b_m = b_sm; b_n = b_sn; b_pend = 1'b0;
            end
            if (acc_ok && lg) begin
                b_sm = cm; b_sn = cn; b_pend = 1'b1;
            end
        end else begin
            b_k = 0;
            if (b_pend) begin
                b_m = b_sm; b_n = b_sn; b_pend = 1'b0;
            end else if (acc_ok && lg) begin
                b_m = cm; b_n = cn;
            end
            b_run = run;
        end
        b_rdy   = !b_pend;
        e.rdy   = b_rdy;
        prev_en = e.en;
        sb.push_back(e);

        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk("clk_en_o",    32'(clk_en_o),    32'(got.en));
        chk("period_o",    32'(period_o),    32'(got.per));
        chk("cfg_ready_o", 32'(cfg_ready_o), 32'(got.rdy));
        chk("cfg_err_o",   32'(cfg_err_o),   32'(got.err));
        chk("clk_out",     32'(clk_out),     32'(got.gclk));
    endtask

    task automatic run_for(input int n);
        repeat (n) cyc(1'b1, 1'b0, 0, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cfg_ready", 32'(cfg_ready_o), 32'd1);
        chk("rst_cfg_err",   32'(cfg_err_o),   32'd0);
        chk("rst_clk_en",    32'(clk_en_o),    32'd0);
        chk("rst_period",    32'(period_o),    32'd0);
        chk("rst_clk_out",   32'(clk_out),     32'd0);
        reset_n = 1'b1;

        // T1: default 3/7
        run_for(8);
        c0 = pulses;
        run_for(14);
        chk("t1_pulses_14clk", 32'(pulses - c0), 32'd6);

        // T2: 2/5 mid-period, extra offers ignored while pending
        run_for(3);
        cyc(1'b1, 1'b1, 2, 5);
        repeat (2) cyc(1'b1, 1'b1, 1, 1);
        run_for(16);

        // T3: illegal configs
        cyc(1'b1, 1'b1, 5, 4);
        cyc(1'b1, 1'b1, 0, 3);
        cyc(1'b1, 1'b1, 1, 0);
        run_for(10);

        // T4: accept on the last cycle of a period, then stop while pending
        while (b_k != b_n - 1) cyc(1'b1, 1'b0, 0, 0);
        cyc(1'b1, 1'b1, 3, 7);
        run_for(12);
        cyc(1'b1, 1'b1, 4, 9);
        run_for(1);
        cyc(1'b0, 1'b0, 0, 0);
        cyc(1'b0, 1'b0, 0, 0);
        run_for(19);

        // T5: M=N=15, then 1/15
        cyc(1'b0, 1'b0, 0, 0);
        cyc(1'b0, 1'b1, 15, 15);
        run_for(3);
        c0 = pulses;
        run_for(15);
        chk("t5_full_pulses", 32'(pulses - c0), 32'd15);
        cyc(1'b0, 1'b0, 0, 0);
        cyc(1'b0, 1'b1, 1, 15);
        run_for(16);
        c0 = pulses;
        run_for(15);
        chk("t5_one_pulse", 32'(pulses - c0), 32'd1);

        // T6: async reset while clk_out is high
        cyc(1'b0, 1'b0, 0, 0);
        cyc(1'b0, 1'b1, 15, 15);
        run_for(3);
        chk("t6_pre_clk_out", 32'(clk_out), 32'd1);
        reset_n     = 1'b0;
        run_i       = 1'b0;
        cfg_valid_i = 1'b0;
        #1;
        chk("t6_clk_out_drop", 32'(clk_out),     32'd0);
        chk("t6_clk_en",       32'(clk_en_o),    32'd0);
        chk("t6_cfg_ready",    32'(cfg_ready_o), 32'd1);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("t6_no_runt", 32'(clk_out), 32'd0);
        end
        reset_n = 1'b1;
        b_m = 3; b_n = 7; b_k = 0; b_run = 1'b0; b_pend = 1'b0; b_rdy = 1'b1; prev_en = 1'b0;
        sb.delete();
        cyc(1'b0, 1'b0, 0, 0);
        run_for(15);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
